// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM and the datapath muxes it drives.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 5;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_RESET   = 5'd0;
  localparam state_t ST_FETCH   = 5'd1;
  localparam state_t ST_F_LAT   = 5'd2;
  localparam state_t ST_DECODE  = 5'd3;
  localparam state_t ST_R_EX    = 5'd4;
  localparam state_t ST_R_WB    = 5'd5;
  localparam state_t ST_I_EX    = 5'd6;
  localparam state_t ST_I_WB    = 5'd7;
  localparam state_t ST_ADDR    = 5'd8;
  localparam state_t ST_L_RD    = 5'd9;
  localparam state_t ST_L_LAT   = 5'd10;
  localparam state_t ST_L_WB    = 5'd11;
  localparam state_t ST_S_WR    = 5'd12;
  localparam state_t ST_BEQ     = 5'd13;
  localparam state_t ST_BNE     = 5'd14;
  localparam state_t ST_JMP     = 5'd15;
  localparam state_t ST_EXC     = 5'd16;
  localparam state_t ST_EXC_RD  = 5'd17;
  localparam state_t ST_EXC_LAT = 5'd18;
  localparam state_t ST_EXC_JMP = 5'd19;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] IORD_PC     = 3'd0;
  localparam logic [2:0] IORD_ALUOUT = 3'd2;
  localparam logic [2:0] IORD_EXCPT  = 3'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_A   = 2'd1;
  localparam logic [1:0] SRCA_MDR = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  localparam logic [2:0] PCSRC_RES    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_MDR    = 3'd4;

  localparam logic [3:0] DATASRC_ALUOUT = 4'd0;

  // Full set of datapath controls produced each cycle
  typedef struct packed {
    logic       pc_write;
    logic [2:0] iord;
    logic       mem_wr;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       ab_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [2:0] pc_source;
    logic [3:0] data_src;
    logic       aluout_write;
    logic       mdr_write;
    logic       epc_write;
  } ctrl_t;

  // R-type funct codes the datapath can execute
  function automatic logic funct_known(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
  endfunction

  // ALU operation for an R-type funct
  function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-state counter: cleared by start, saturates at MEM_WAIT-1 and flags done.
module mem_wait_ctr #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done_c
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_c = (cnt_q == LAST);

  // Clear on start, otherwise count up and hold at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (!done_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM with memory wait states.
// Build option: define CTRL_OVF_EXC_EN to trap overflow and unknown instructions
// through the EPC/exception-vector sequence.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Gt,
  input  logic       Eq,
  input  logic       Lt,
  input  logic       Ng,
  input  logic       Zr,
  input  logic       Ofw,
  output logic       PC_Write,
  output logic [2:0] IorD,
  output logic       MEM_write_or_read,
  output logic       IR_Write,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       AB_Write,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtrl,
  output logic [2:0] PCSource,
  output logic [3:0] DataSrc,
  output logic       ALUOut_Write,
  output logic       MDR_Write,
  output logic       EPC_Write
);

  import cpu_ctrl_pkg::*;

  state_t state_q, state_d;
  ctrl_t  ctrl_c;
  logic   wait_done_c;
  logic   ovf_trap_c;
  logic   unused_flags;

`ifdef CTRL_OVF_EXC_EN
  localparam state_t UNKNOWN_NEXT = ST_EXC;
  assign ovf_trap_c   = Ofw;
  assign unused_flags = ^{Gt, Lt, Ng, Zr};
`else
  localparam state_t UNKNOWN_NEXT = ST_FETCH;
  assign ovf_trap_c   = 1'b0;
  assign unused_flags = ^{Gt, Lt, Ng, Zr, Ofw};
`endif

  // Every state change restarts the wait count, so a wait state always begins at 0
  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .start  (state_d != state_q),
    .done_c (wait_done_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  if (wait_done_c) state_d = ST_F_LAT;
      ST_F_LAT:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = funct_known(funct) ? ST_R_EX : UNKNOWN_NEXT;
          OP_ADDI:  state_d = ST_I_EX;
          OP_LW:    state_d = ST_ADDR;
          OP_SW:    state_d = ST_ADDR;
          OP_BEQ:   state_d = ST_BEQ;
          OP_BNE:   state_d = ST_BNE;
          OP_J:     state_d = ST_JMP;
          default:  state_d = UNKNOWN_NEXT;
        endcase
      end
      ST_R_EX:    state_d = (ovf_trap_c && (funct != FN_AND)) ? ST_EXC : ST_R_WB;
      ST_I_EX:    state_d = ovf_trap_c ? ST_EXC : ST_I_WB;
      ST_ADDR:    state_d = (opcode == OP_LW) ? ST_L_RD : ST_S_WR;
      ST_L_RD:    if (wait_done_c) state_d = ST_L_LAT;
      ST_L_LAT:   state_d = ST_L_WB;
      ST_EXC:     state_d = ST_EXC_RD;
      ST_EXC_RD:  if (wait_done_c) state_d = ST_EXC_LAT;
      ST_EXC_LAT: state_d = ST_EXC_JMP;
      ST_R_WB, ST_I_WB, ST_L_WB, ST_S_WR,
      ST_BEQ, ST_BNE, ST_JMP, ST_EXC_JMP: state_d = ST_FETCH;
      default:    state_d = ST_RESET;
    endcase
  end

  // Output decode from the current state (branch enables follow Eq)
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.iord      = IORD_PC;
        ctrl_c.alu_src_a = SRCA_PC;
        ctrl_c.alu_src_b = SRCB_4;
        ctrl_c.alu_ctrl  = ALU_ADD;
      end
      ST_F_LAT: begin
        ctrl_c.ir_write  = 1'b1;
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_RES;
        // keep PC+4 on the ALU result while the PC loads it
        ctrl_c.alu_src_a = SRCA_PC;
        ctrl_c.alu_src_b = SRCB_4;
        ctrl_c.alu_ctrl  = ALU_ADD;
      end
      ST_DECODE: begin
        ctrl_c.ab_write     = 1'b1;
        ctrl_c.alu_src_a    = SRCA_PC;
        ctrl_c.alu_src_b    = SRCB_IMM_SH;
        ctrl_c.alu_ctrl     = ALU_ADD;
        ctrl_c.aluout_write = 1'b1;
      end
      ST_R_EX: begin
        ctrl_c.alu_src_a    = SRCA_A;
        ctrl_c.alu_src_b    = SRCB_B;
        ctrl_c.alu_ctrl     = alu_from_funct(funct);
        ctrl_c.aluout_write = 1'b1;
      end
      ST_R_WB: begin
        ctrl_c.reg_dst   = REGDST_RD;
        ctrl_c.data_src  = DATASRC_ALUOUT;
        ctrl_c.reg_write = 1'b1;
      end
      ST_I_EX, ST_ADDR: begin
        ctrl_c.alu_src_a    = SRCA_A;
        ctrl_c.alu_src_b    = SRCB_IMM;
        ctrl_c.alu_ctrl     = ALU_ADD;
        ctrl_c.aluout_write = 1'b1;
      end
      ST_I_WB: begin
        ctrl_c.reg_dst   = REGDST_RT;
        ctrl_c.reg_write = 1'b1;
      end
      ST_L_RD:  ctrl_c.iord = IORD_ALUOUT;
      ST_L_LAT: ctrl_c.mdr_write = 1'b1;
      ST_L_WB: begin
        ctrl_c.data_src     = DATASRC_ALUOUT;
        ctrl_c.alu_src_a    = SRCA_MDR;
        ctrl_c.alu_ctrl     = ALU_PASSA;
        ctrl_c.aluout_write = 1'b1;
        ctrl_c.reg_dst      = REGDST_RT;
        ctrl_c.reg_write    = 1'b1;
      end
      ST_S_WR: begin
        ctrl_c.iord   = IORD_ALUOUT;
        ctrl_c.mem_wr = 1'b1;
      end
      ST_BEQ, ST_BNE: begin
        ctrl_c.alu_src_a = SRCA_A;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_ctrl  = ALU_CMP;
        ctrl_c.pc_source = PCSRC_ALUOUT;
        ctrl_c.pc_write  = (state_q == ST_BEQ) ? Eq : !Eq;
      end
      ST_JMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
      end
      ST_EXC: begin
        ctrl_c.alu_src_a = SRCA_PC;
        ctrl_c.alu_src_b = SRCB_4;
        ctrl_c.alu_ctrl  = ALU_SUB;
`ifdef CTRL_OVF_EXC_EN
        ctrl_c.epc_write = 1'b1;
`endif
      end
      ST_EXC_RD:  ctrl_c.iord = IORD_EXCPT;
      ST_EXC_LAT: ctrl_c.mdr_write = 1'b1;
      ST_EXC_JMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_MDR;
      end
      default: ctrl_c = '0;
    endcase
  end

  assign PC_Write          = ctrl_c.pc_write;
  assign IorD              = ctrl_c.iord;
  assign MEM_write_or_read = ctrl_c.mem_wr;
  assign IR_Write          = ctrl_c.ir_write;
  assign RegDst            = ctrl_c.reg_dst;
  assign RegWrite          = ctrl_c.reg_write;
  assign AB_Write          = ctrl_c.ab_write;
  assign ALUSrcA           = ctrl_c.alu_src_a;
  assign ALUSrcB           = ctrl_c.alu_src_b;
  assign ALUCtrl           = ctrl_c.alu_ctrl;
  assign PCSource          = ctrl_c.pc_source;
  assign DataSrc           = ctrl_c.data_src;
  assign ALUOut_Write      = ctrl_c.aluout_write;
  assign MDR_Write         = ctrl_c.mdr_write;
  assign EPC_Write         = ctrl_c.epc_write;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected control traces built from phase rules.
// Honours CTRL_OVF_EXC_EN when defined for the build.
module tb_mc_ctrl_fsm;

  localparam int unsigned MW = 2;
`ifdef CTRL_OVF_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic       clk, reset;
  logic [5:0] opcode, funct;
  logic       Gt, Eq, Lt, Ng, Zr, Ofw;
  logic       PC_Write, MEM_write_or_read, IR_Write, RegWrite, AB_Write;
  logic       ALUOut_Write, MDR_Write, EPC_Write;
  logic [2:0] IorD, ALUCtrl, PCSource;
  logic [1:0] RegDst, ALUSrcA, ALUSrcB;
  logic [3:0] DataSrc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];

  mc_ctrl_fsm #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .Gt(Gt), .Eq(Eq), .Lt(Lt), .Ng(Ng), .Zr(Zr), .Ofw(Ofw),
    .PC_Write(PC_Write), .IorD(IorD), .MEM_write_or_read(MEM_write_or_read),
    .IR_Write(IR_Write), .RegDst(RegDst), .RegWrite(RegWrite), .AB_Write(AB_Write),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .PCSource(PCSource),
    .DataSrc(DataSrc), .ALUOut_Write(ALUOut_Write), .MDR_Write(MDR_Write),
    .EPC_Write(EPC_Write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bit layout: pcw[26] iord[25:23] mw[22] irw[21] rdst[20:19] rw[18] abw[17]
  // sa[16:15] sb[14:13] ac[12:10] ps[9:7] ds[6:3] aow[2] mdrw[1] epcw[0]
  function automatic logic [26:0] cv(input int pcw, input int iord, input int mw, input int irw,
                                     input int rdst, input int rw, input int abw, input int sa,
                                     input int sb, input int ac, input int ps, input int ds,
                                     input int aow, input int mdrw, input int epcw);
    return {1'(pcw), 3'(iord), 1'(mw), 1'(irw), 2'(rdst), 1'(rw), 1'(abw), 2'(sa),
            2'(sb), 3'(ac), 3'(ps), 4'(ds), 1'(aow), 1'(mdrw), 1'(epcw)};
  endfunction

  function automatic logic [26:0] obs();
    return {PC_Write, IorD, MEM_write_or_read, IR_Write, RegDst, RegWrite, AB_Write,
            ALUSrcA, ALUSrcB, ALUCtrl, PCSource, DataSrc, ALUOut_Write, MDR_Write, EPC_Write};
  endfunction

  function automatic logic [26:0] fetch_vec();
    return cv(0,0,0,0,0,0,0,0,1,1,0,0,0,0,0);
  endfunction

  task automatic push_exc();
    exp_q.push_back(cv(0,0,0,0,0,0,0,0,1,2,0,0,0,0,1));
    repeat (MW) exp_q.push_back(cv(0,3,0,0,0,0,0,0,0,0,0,0,0,0,0));
    exp_q.push_back(cv(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
    exp_q.push_back(cv(1,0,0,0,0,0,0,0,0,0,4,0,0,0,0));
  endtask

  // Expected per-cycle control vectors for one instruction, from the instruction phases
  task automatic build_exp(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic ofw);
    int ac;
    exp_q.delete();
    repeat (MW) exp_q.push_back(fetch_vec());
    exp_q.push_back(cv(1,0,0,1,0,0,0,0,1,1,0,0,0,0,0));
    exp_q.push_back(cv(0,0,0,0,0,0,1,0,3,1,0,0,1,0,0));
    case (op)
      6'h00: begin
        ac = (fn == 6'h20) ? 1 : (fn == 6'h22) ? 2 : (fn == 6'h24) ? 3 : 0;
        if (ac == 0) begin
          if (EXC_EN) push_exc();
        end else begin
          exp_q.push_back(cv(0,0,0,0,0,0,0,1,0,ac,0,0,1,0,0));
          if (EXC_EN && ofw && ac != 3) push_exc();
          else exp_q.push_back(cv(0,0,0,0,1,1,0,0,0,0,0,0,0,0,0));
        end
      end
      6'h08: begin
        exp_q.push_back(cv(0,0,0,0,0,0,0,1,2,1,0,0,1,0,0));
        if (EXC_EN && ofw) push_exc();
        else exp_q.push_back(cv(0,0,0,0,0,1,0,0,0,0,0,0,0,0,0));
      end
      6'h23: begin
        exp_q.push_back(cv(0,0,0,0,0,0,0,1,2,1,0,0,1,0,0));
        repeat (MW) exp_q.push_back(cv(0,2,0,0,0,0,0,0,0,0,0,0,0,0,0));
        exp_q.push_back(cv(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        exp_q.push_back(cv(0,0,0,0,0,1,0,2,0,0,0,0,1,0,0));
      end
      6'h2B: begin
        exp_q.push_back(cv(0,0,0,0,0,0,0,1,2,1,0,0,1,0,0));
        exp_q.push_back(cv(0,2,1,0,0,0,0,0,0,0,0,0,0,0,0));
      end
      6'h04: exp_q.push_back(cv(int'(eq),0,0,0,0,0,0,1,0,7,1,0,0,0,0));
      6'h05: exp_q.push_back(cv(int'(!eq),0,0,0,0,0,0,1,0,7,1,0,0,0,0));
      6'h02: exp_q.push_back(cv(1,0,0,0,0,0,0,0,0,0,2,0,0,0,0));
      default: if (EXC_EN) push_exc();
    endcase
  endtask

  // Runs one instruction from its first FETCH cycle; abort_at >= 0 pulls reset in that cycle,
  // -2 picks a random abort point occasionally.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                           input logic ofw, input int abort_at, input string tag);
    int ab;
    bit stop;
    opcode = op; funct = fn; Eq = eq; Ofw = ofw;
    Gt = 1'($urandom); Lt = 1'($urandom); Ng = 1'($urandom); Zr = 1'($urandom);
    build_exp(op, fn, eq, ofw);
    obs_q.delete();
    ab = abort_at;
    if (ab == -2) ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
    stop = 1'b0;
    for (int i = 0; i < exp_q.size() && !stop; i++) begin
      if (i == ab) begin
        check($sformatf("%s_pre_abort_c%0d", tag, i), 32'(obs()), 32'(exp_q[i]));
        #2 reset = 1'b0;
        #1 check($sformatf("%s_async_rst", tag), 32'(obs()), 32'd0);
        @(negedge clk);
        check($sformatf("%s_rst_hold", tag), 32'(obs()), 32'd0);
        reset = 1'b1;
        #1 check($sformatf("%s_rst_release", tag), 32'(obs()), 32'd0);
        @(posedge clk); #1;
        stop = 1'b1;
      end else begin
        @(negedge clk);
        obs_q.push_back(obs());
        check($sformatf("%s_c%0d", tag, i), 32'(obs()), 32'(exp_q[i]));
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic int cnt_bit(input int pos);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][pos]) n++;
    return n;
  endfunction

  function automatic int first_bit(input int pos);
    foreach (obs_q[i]) if (obs_q[i][pos]) return i;
    return -1;
  endfunction

  function automatic int cnt_iord(input int val);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][25:23] == 3'(val)) n++;
    return n;
  endfunction

  function automatic int first_iord(input int val);
    foreach (obs_q[i]) if (obs_q[i][25:23] == 3'(val)) return i;
    return -1;
  endfunction

  function automatic int first_ps(input int val);
    foreach (obs_q[i]) if (obs_q[i][9:7] == 3'(val)) return i;
    return -1;
  endfunction

  logic [5:0] valid_ops [0:6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] bad_ops   [0:3] = '{6'h01, 6'h3F, 6'h10, 6'h2A};

  initial begin
    logic [5:0] op, fn;
    int k;
    reset = 1'b0; opcode = '0; funct = '0;
    Gt = 0; Eq = 0; Lt = 0; Ng = 0; Zr = 0; Ofw = 0;
    repeat (3) @(posedge clk);
    #1 check("rst_outputs", 32'(obs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_release_state", 32'(obs()), 32'd0);
    @(posedge clk); #1;

    // reset asserted in the second FETCH cycle, then a clean ADD
    run_instr(6'h00, 6'h20, 1'b0, 1'b0, 1, "fetch_abort");
    run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1, "add");
    check("add_rw_count", 32'(cnt_bit(18)), 32'd1);
    check("add_rw_cycle", 32'(first_bit(18)), 32'd5);
    check("add_rd_at_wb", 32'(obs_q[5][20:19]), 32'd1);
    check("add_pcw_count", 32'(cnt_bit(26)), 32'd1);
    check("add_pcw_cycle", 32'(first_bit(26)), 32'(MW));

    run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1, "lw");
    check("lw_iord2_cycles", 32'(cnt_iord(2)), 32'd2);
    check("lw_mdr_cycle", 32'(first_bit(1)), 32'd7);
    check("lw_rw_cycle", 32'(first_bit(18)), 32'd8);
    check("lw_rt_at_wb", 32'(obs_q[8][20:19]), 32'd0);
    check("lw_next_fetch", 32'(obs()), 32'(fetch_vec()));

    run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1, "beq_t");
    check("beq_t_pcw", 32'(obs_q[4][26]), 32'd1);
    check("beq_t_ps", 32'(obs_q[4][9:7]), 32'd1);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1, "beq_nt");
    check("beq_nt_pcw_count", 32'(cnt_bit(26)), 32'd1);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0, -1, "bne_nt");
    check("bne_nt_pcw_count", 32'(cnt_bit(26)), 32'd1);

    run_instr(6'h2B, 6'h00, 1'b0, 1'b0, -1, "sw");
    check("sw_wr_count", 32'(cnt_bit(22)), 32'd1);
    check("sw_wr_iord", 32'(obs_q[first_bit(22) < 0 ? 0 : first_bit(22)][25:23]), 32'd2);
    check("sw_rw_count", 32'(cnt_bit(18)), 32'd0);
    // reset in the store cycle itself
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0, MW + 3, "sw_abort");

    run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1, "addi_ovf");
    if (EXC_EN) begin
      check("addi_ovf_rw_count", 32'(cnt_bit(18)), 32'd0);
      check("addi_ovf_epc_cycle", 32'(first_bit(0)), 32'(MW + 3));
      check("addi_ovf_iord3_cycle", 32'(first_iord(3)), 32'(MW + 4));
      check("addi_ovf_ps4_cycle", 32'(first_ps(4)), 32'(2 * MW + 5));
    end else begin
      check("addi_ovf_rw_count", 32'(cnt_bit(18)), 32'd1);
      check("addi_ovf_epc_count", 32'(cnt_bit(0)), 32'd0);
    end
    check("addi_ovf_next_fetch", 32'(obs()), 32'(fetch_vec()));

    run_instr(6'h01, 6'h00, 1'b0, 1'b0, -1, "unknown_op");
    run_instr(6'h00, 6'h3F, 1'b0, 1'b0, -1, "unknown_fn");

    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 7));
      op = (k < 7) ? valid_ops[k] : bad_ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        default: fn = 6'($urandom);
      endcase
      run_instr(op, fn, 1'($urandom), 1'($urandom), -2, $sformatf("rnd%0d_op%0h", n, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
